// File: rtl/sram_burst_ctrl_if.sv
// Signal bundle between a burst requester, sram_burst_ctrl and the SRAM it drives.
// Handshakes (cmd, wr, rd): a transfer happens on a rising edge where valid and ready are both 1; valid holds its payload until then.
interface sram_burst_ctrl_if #(
    parameter int DW = 64,
    parameter int AW = 6
);
    logic          i_cmd_valid;
    logic          o_cmd_ready;
    logic          i_cmd_write;
    logic [AW-1:0] i_cmd_addr;
    logic [AW-1:0] i_cmd_len;
    logic          i_wr_valid;
    logic          o_wr_ready;
    logic [DW-1:0] i_wr_data;
    logic          o_rd_valid;
    logic          i_rd_ready;
    logic [DW-1:0] o_rd_data;
    logic          o_done;
    logic [DW-1:0] o_mem_data;
    logic [AW-1:0] o_mem_addr;
    logic          o_mem_wen;
    logic          o_mem_oen;
    logic [DW-1:0] i_mem_data;
    logic [1:0]    o_dbg_state;

    modport slave (
        input  i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_len,
        input  i_wr_valid, i_wr_data, i_rd_ready, i_mem_data,
        output o_cmd_ready, o_wr_ready, o_rd_valid, o_rd_data, o_done,
        output o_mem_data, o_mem_addr, o_mem_wen, o_mem_oen, o_dbg_state
    );

    modport master (
        output i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_len,
        output i_wr_valid, i_wr_data, i_rd_ready, i_mem_data,
        input  o_cmd_ready, o_wr_ready, o_rd_valid, o_rd_data, o_done,
        input  o_mem_data, o_mem_addr, o_mem_wen, o_mem_oen, o_dbg_state
    );
endinterface

// File: rtl/sram_burst_ctrl.sv
// Burst controller in front of a 64 x 64-bit SRAM: streams write beats in, read beats out
// through a small return FIFO, one beat per cycle, with mutually exclusive wen/oen strobes.
module sram_burst_ctrl #(
    parameter int DW = 64,
    parameter int AW = 6,
    parameter int FD = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    sram_burst_ctrl_if.slave bus
);
    localparam int PW = $clog2(FD);
    localparam logic [AW:0]   ONE_BEAT  = (AW+1)'(1);
    localparam logic [AW-1:0] ADDR_STEP = AW'(1);

    typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2, DRAIN = 2'd3} state_t;

    state_t        r_state;
    logic          r_cmd_ready;
    logic          r_done;
    logic          r_mem_wen;
    logic          r_mem_oen;
    logic          r_oen_d;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_mem_addr;
    logic [AW:0]   r_remain;
    logic [DW-1:0] r_mem_data;
    logic [DW-1:0] r_fifo [FD];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;

    logic          w_push;
    logic          w_pop;
    logic          w_can_issue;
    logic [PW+1:0] w_occupancy;

    // SRAM data is valid the cycle after an oen cycle, so it is captured one cycle later still.
    assign w_push      = r_oen_d;
    assign w_pop       = (r_count != '0) && bus.i_rd_ready;
    assign w_occupancy = (PW+2)'(r_count) + (PW+2)'(r_mem_oen) + (PW+2)'(r_oen_d);
    assign w_can_issue = w_occupancy < (PW+2)'(FD);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b0;
            r_done      <= 1'b0;
            r_mem_wen   <= 1'b0;
            r_mem_oen   <= 1'b0;
            r_oen_d     <= 1'b0;
            r_addr      <= '0;
            r_mem_addr  <= '0;
            r_remain    <= '0;
            r_mem_data  <= '0;
        end else begin
            r_done    <= 1'b0;
            r_mem_wen <= 1'b0;
            r_mem_oen <= 1'b0;
            r_oen_d   <= r_mem_oen;
            case (r_state)
                IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (bus.i_cmd_valid && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_addr      <= bus.i_cmd_addr;
                        r_remain    <= (AW+1)'(bus.i_cmd_len) + ONE_BEAT;
                        r_state     <= bus.i_cmd_write ? WRITE : READ;
                    end
                end
                WRITE: begin
                    if (bus.i_wr_valid) begin
                        r_mem_wen  <= 1'b1;
                        r_mem_addr <= r_addr;
                        r_mem_data <= bus.i_wr_data;
                        r_addr     <= r_addr + ADDR_STEP;
                        r_remain   <= r_remain - ONE_BEAT;
                        if (r_remain == ONE_BEAT) begin
                            r_state     <= IDLE;
                            r_done      <= 1'b1;
                            r_cmd_ready <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (w_can_issue) begin
                        r_mem_oen  <= 1'b1;
                        r_mem_addr <= r_addr;
                        r_addr     <= r_addr + ADDR_STEP;
                        r_remain   <= r_remain - ONE_BEAT;
                        if (r_remain == ONE_BEAT) r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Finish on the pop of the final beat, with nothing left in flight.
                    if (!r_mem_oen && !r_oen_d && r_count == (PW+1)'(1) && w_pop) begin
                        r_state     <= IDLE;
                        r_done      <= 1'b1;
                        r_cmd_ready <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            if (w_push && !w_pop)      r_count <= r_count + (PW+1)'(1);
            else if (!w_push && w_pop) r_count <= r_count - (PW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_fifo[r_wptr] <= bus.i_mem_data;
    end

    assign bus.o_cmd_ready = r_cmd_ready;
    assign bus.o_wr_ready  = (r_state == WRITE);
    assign bus.o_rd_valid  = (r_count != '0);
    assign bus.o_rd_data   = r_fifo[r_rptr];
    assign bus.o_done      = r_done;
    assign bus.o_mem_data  = r_mem_data;
    assign bus.o_mem_addr  = r_mem_addr;
    assign bus.o_mem_wen   = r_mem_wen;
    assign bus.o_mem_oen   = r_mem_oen;
    assign bus.o_dbg_state = r_state;
endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Self-checking bench for sram_burst_ctrl: SRAM model on the memory side, reference memory
// array plus expected queues predicting write strobes and read returns.
`timescale 1ns/1ps
module tb_sram_burst_ctrl;
    localparam int DW = 64;
    localparam int AW = 6;
    localparam int FD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    sram_burst_ctrl_if #(.DW(DW), .AW(AW)) bus ();
    sram_burst_ctrl #(.DW(DW), .AW(AW), .FD(FD)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: synchronous write, registered read data
    logic [DW-1:0] sram [64];
    logic [DW-1:0] sram_q;
    always @(posedge clk) begin
        if (bus.o_mem_wen) sram[bus.o_mem_addr] <= bus.o_mem_data;
        if (bus.o_mem_oen) sram_q <= sram[bus.o_mem_addr];
    end
    assign bus.i_mem_data = sram_q;

    // reference model and scoreboard
    logic [DW-1:0] ref_mem [64];
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] exp_addr_q[$];
    logic [DW-1:0] wdata_q[$];

    // monitor, sampled on the falling edge
    logic [DW-1:0] wen_data_q[$];
    logic [AW-1:0] wen_addr_q[$];
    logic [DW-1:0] rd_q[$];
    int wen_cyc_q[$];
    int rd_cyc_q[$];
    int wr_hs_cyc_q[$];
    int oen_cnt, done_cnt, done_cyc, both_cnt;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_mem_wen) begin
                wen_addr_q.push_back(bus.o_mem_addr);
                wen_data_q.push_back(bus.o_mem_data);
                wen_cyc_q.push_back(cyc);
            end
            if (bus.o_mem_oen) oen_cnt++;
            if (bus.o_mem_wen && bus.o_mem_oen) both_cnt++;
            if (bus.o_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.o_rd_valid && bus.i_rd_ready) begin
                rd_q.push_back(bus.o_rd_data);
                rd_cyc_q.push_back(cyc);
            end
            if (bus.i_wr_valid && bus.o_wr_ready) wr_hs_cyc_q.push_back(cyc);
        end
    end

    task automatic clear_mon();
        wen_data_q.delete(); wen_addr_q.delete(); rd_q.delete();
        wen_cyc_q.delete(); rd_cyc_q.delete(); wr_hs_cyc_q.delete();
        oen_cnt = 0; done_cnt = 0; done_cyc = -1; both_cnt = 0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic send_cmd(input logic wr, input logic [AW-1:0] addr, input logic [AW-1:0] len,
                            output int acc);
        acc = -1;
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_write = wr;
        bus.i_cmd_addr  = addr;
        bus.i_cmd_len   = len;
        for (int n = 0; n < 50; n++) begin
            if (bus.o_cmd_ready) begin
                step(1);
                acc = cyc;
                break;
            end
            step(1);
        end
        bus.i_cmd_valid = 1'b0;
        n_checks++;
        if (acc < 0) begin
            n_fail++;
            $display("FAIL cmd_accept: no handshake in 50 cycles, need o_cmd_ready=1");
        end
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input int n, input bit gapped);
        int i = 0;
        int guard = 0;
        int acc;
        exp_q.delete();
        exp_addr_q.delete();
        for (int k = 0; k < n; k++) begin
            exp_addr_q.push_back(AW'((int'(addr) + k) % 64));
            exp_q.push_back(wdata_q[k]);
            ref_mem[(int'(addr) + k) % 64] = wdata_q[k];
        end
        send_cmd(1'b1, addr, AW'(n - 1), acc);
        while (i < n && guard < 1000) begin
            bus.i_wr_valid = gapped ? ((guard % 2 == 0) && ($urandom_range(0, 3) != 0)) : 1'b1;
            bus.i_wr_data  = wdata_q[i];
            if (bus.i_wr_valid && bus.o_wr_ready) i++;
            step(1);
            guard++;
        end
        bus.i_wr_valid = 1'b0;
        n_checks++;
        if (i < n) begin
            n_fail++;
            $display("FAIL wr_timeout: %0d beats accepted, need %0d", i, n);
        end
        step(3);
    endtask

    task automatic wait_rd(input int n, input bit rand_ready);
        int guard = 0;
        while (rd_q.size() < n && guard < 2000) begin
            bus.i_rd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            step(1);
            guard++;
        end
        bus.i_rd_ready = 1'b1;
        n_checks++;
        if (rd_q.size() < n) begin
            n_fail++;
            $display("FAIL rd_timeout: got %0d beats, need %0d", rd_q.size(), n);
        end
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input int n, input bit rand_ready, output int acc);
        exp_q.delete();
        for (int k = 0; k < n; k++) exp_q.push_back(ref_mem[(int'(addr) + k) % 64]);
        bus.i_rd_ready = 1'b1;
        send_cmd(1'b0, addr, AW'(n - 1), acc);
        wait_rd(n, rand_ready);
        step(3);
    endtask

    function automatic logic [DW-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // tests
    task automatic test_reset();
        step(3);
        n_checks++;
        if (bus.o_cmd_ready !== 1'b0 || bus.o_mem_wen !== 1'b0 || bus.o_mem_oen !== 1'b0 ||
            bus.o_rd_valid !== 1'b0 || bus.o_done !== 1'b0 || bus.o_wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: cmd_ready=%b wen=%b oen=%b rd_valid=%b done=%b wr_ready=%b, need all 0",
                     bus.o_cmd_ready, bus.o_mem_wen, bus.o_mem_oen, bus.o_rd_valid, bus.o_done, bus.o_wr_ready);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.o_cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b, need 0 before first edge", bus.o_cmd_ready);
        end
        step(1);
        n_checks++;
        if (bus.o_cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_rise: got %b, need 1", bus.o_cmd_ready);
        end
    endtask

    task automatic test_write_full();
        clear_mon();
        wdata_q.delete();
        for (int k = 0; k < 64; k++) wdata_q.push_back(DW'(k));
        do_write(6'd0, 64, 1'b0);
        n_checks++;
        if (wen_addr_q.size() != 64) begin
            n_fail++;
            $display("FAIL wfull_count: got %0d wen cycles, need 64", wen_addr_q.size());
        end
        for (int k = 0; k < 64 && k < wen_addr_q.size(); k++) begin
            n_checks++;
            if (wen_addr_q[k] !== exp_addr_q[k] || wen_data_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL wfull_beat%0d: addr %0d data %h, need addr %0d data %h",
                         k, wen_addr_q[k], wen_data_q[k], exp_addr_q[k], exp_q[k]);
            end
        end
        if (wen_cyc_q.size() == 64) begin
            n_checks++;
            if (wen_cyc_q[63] - wen_cyc_q[0] != 63 || done_cyc != wen_cyc_q[63]) begin
                n_fail++;
                $display("FAIL wfull_timing: span %0d done_cyc %0d, need span 63 done_cyc %0d",
                         wen_cyc_q[63] - wen_cyc_q[0], done_cyc, wen_cyc_q[63]);
            end
        end
        n_checks++;
        if (done_cnt != 1 || oen_cnt != 0 || both_cnt != 0) begin
            n_fail++;
            $display("FAIL wfull_misc: done %0d oen %0d both %0d, need 1 0 0", done_cnt, oen_cnt, both_cnt);
        end
    endtask

    task automatic test_read_full();
        int acc;
        clear_mon();
        do_read(6'd0, 64, 1'b0, acc);
        for (int k = 0; k < 64 && k < rd_q.size(); k++) begin
            n_checks++;
            if (rd_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL rfull_beat%0d: got %h, need %h", k, rd_q[k], exp_q[k]);
            end
        end
        if (rd_cyc_q.size() == 64) begin
            n_checks++;
            if (rd_cyc_q[0] - acc != 3 || rd_cyc_q[63] - rd_cyc_q[0] != 63 || done_cyc != rd_cyc_q[63] + 1) begin
                n_fail++;
                $display("FAIL rfull_timing: latency %0d span %0d done_cyc %0d, need 3 63 %0d",
                         rd_cyc_q[0] - acc, rd_cyc_q[63] - rd_cyc_q[0], done_cyc, rd_cyc_q[63] + 1);
            end
        end
        n_checks++;
        if (done_cnt != 1 || oen_cnt != 64 || wen_addr_q.size() != 0 || both_cnt != 0) begin
            n_fail++;
            $display("FAIL rfull_misc: done %0d oen %0d wen %0d both %0d, need 1 64 0 0",
                     done_cnt, oen_cnt, wen_addr_q.size(), both_cnt);
        end
    endtask

    task automatic test_wrap();
        int acc;
        clear_mon();
        wdata_q.delete();
        for (int k = 0; k < 4; k++) wdata_q.push_back(rnd64());
        do_write(6'd62, 4, 1'b0);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (k >= wen_addr_q.size() || wen_addr_q[k] !== exp_addr_q[k] || wen_data_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL wrap_write%0d: %0d beats seen, need addr %0d data %h", k, wen_addr_q.size(),
                         exp_addr_q[k], exp_q[k]);
            end
        end
        clear_mon();
        do_read(6'd62, 4, 1'b1, acc);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (k >= rd_q.size() || rd_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL wrap_read%0d: %0d beats seen, need %h", k, rd_q.size(), exp_q[k]);
            end
        end
        n_checks++;
        if (done_cnt != 1) begin
            n_fail++;
            $display("FAIL wrap_done: got %0d pulses, need 1", done_cnt);
        end
    endtask

    task automatic test_backpressure();
        int acc;
        logic [AW-1:0] addr;
        addr = AW'($urandom_range(0, 63));
        clear_mon();
        exp_q.delete();
        for (int k = 0; k < 16; k++) exp_q.push_back(ref_mem[(int'(addr) + k) % 64]);
        bus.i_rd_ready = 1'b0;
        send_cmd(1'b0, addr, 6'd15, acc);
        step(10);
        n_checks++;
        if (oen_cnt != FD || bus.o_rd_valid !== 1'b1 || rd_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_stall: oen %0d rd_valid %b popped %0d, need %0d 1 0",
                     oen_cnt, bus.o_rd_valid, rd_q.size(), FD);
        end
        wait_rd(16, 1'b1);
        step(3);
        for (int k = 0; k < 16 && k < rd_q.size(); k++) begin
            n_checks++;
            if (rd_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL bp_beat%0d: got %h, need %h", k, rd_q[k], exp_q[k]);
            end
        end
        n_checks++;
        if (done_cnt != 1 || oen_cnt != 16) begin
            n_fail++;
            $display("FAIL bp_misc: done %0d oen %0d, need 1 16", done_cnt, oen_cnt);
        end
    endtask

    task automatic test_gapped_writes();
        clear_mon();
        wdata_q.delete();
        for (int k = 0; k < 8; k++) wdata_q.push_back(rnd64());
        do_write(AW'($urandom_range(0, 63)), 8, 1'b1);
        n_checks++;
        if (wen_addr_q.size() != 8 || wr_hs_cyc_q.size() != 8) begin
            n_fail++;
            $display("FAIL gap_count: wen %0d handshakes %0d, need 8 8", wen_addr_q.size(), wr_hs_cyc_q.size());
        end
        for (int k = 0; k < 8 && k < wen_addr_q.size() && k < wr_hs_cyc_q.size(); k++) begin
            n_checks++;
            if (wen_cyc_q[k] != wr_hs_cyc_q[k] + 1 || wen_addr_q[k] !== exp_addr_q[k] || wen_data_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL gap_beat%0d: cyc %0d addr %0d data %h, need cyc %0d addr %0d data %h", k,
                         wen_cyc_q[k], wen_addr_q[k], wen_data_q[k], wr_hs_cyc_q[k] + 1, exp_addr_q[k], exp_q[k]);
            end
        end
        n_checks++;
        if (done_cnt != 1 || oen_cnt != 0) begin
            n_fail++;
            $display("FAIL gap_misc: done %0d oen %0d, need 1 0", done_cnt, oen_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int acc, n;
        logic [AW-1:0] addr;
        for (int t = 0; t < 6; t++) begin
            n = (t == 0) ? 1 : int'($urandom_range(1, 12));
            addr = AW'($urandom_range(0, 63));
            clear_mon();
            if ((t % 2 == 0) || ($urandom_range(0, 1) == 1)) begin
                wdata_q.delete();
                for (int k = 0; k < n; k++) wdata_q.push_back(rnd64());
                do_write(addr, n, 1'($urandom_range(0, 1)));
                for (int k = 0; k < n; k++) begin
                    n_checks++;
                    if (k >= wen_addr_q.size() || wen_addr_q[k] !== exp_addr_q[k] || wen_data_q[k] !== exp_q[k]) begin
                        n_fail++;
                        $display("FAIL b2b%0d_wbeat%0d: %0d beats seen, need addr %0d data %h", t, k,
                                 wen_addr_q.size(), exp_addr_q[k], exp_q[k]);
                    end
                end
            end else begin
                do_read(addr, n, 1'b1, acc);
                for (int k = 0; k < n; k++) begin
                    n_checks++;
                    if (k >= rd_q.size() || rd_q[k] !== exp_q[k]) begin
                        n_fail++;
                        $display("FAIL b2b%0d_rbeat%0d: %0d beats seen, need %h", t, k, rd_q.size(), exp_q[k]);
                    end
                end
            end
            n_checks++;
            if (done_cnt != 1 || both_cnt != 0) begin
                n_fail++;
                $display("FAIL b2b%0d_misc: done %0d both %0d, need 1 0", t, done_cnt, both_cnt);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int acc;
        clear_mon();
        bus.i_rd_ready = 1'b1;
        send_cmd(1'b0, AW'($urandom_range(0, 63)), 6'd9, acc);
        wait_rd(5, 1'b0);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (bus.o_mem_wen !== 1'b0 || bus.o_mem_oen !== 1'b0 || bus.o_rd_valid !== 1'b0 ||
            bus.o_done !== 1'b0 || bus.o_cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_outputs: wen=%b oen=%b rd_valid=%b done=%b cmd_ready=%b, need all 0",
                     bus.o_mem_wen, bus.o_mem_oen, bus.o_rd_valid, bus.o_done, bus.o_cmd_ready);
        end
        step(2);
        rst = 1'b0;
        clear_mon();
        step(1);
        n_checks++;
        if (bus.o_cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_ready: got %b, need 1", bus.o_cmd_ready);
        end
        step(4);
        n_checks++;
        if (done_cnt != 0 || bus.o_rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_abandon: done %0d rd_valid %b, need 0 0", done_cnt, bus.o_rd_valid);
        end
        wdata_q.delete();
        for (int k = 0; k < 3; k++) wdata_q.push_back(rnd64());
        do_write(6'd10, 3, 1'b0);
        clear_mon();
        do_read(6'd10, 3, 1'b0, acc);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (k >= rd_q.size() || rd_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL midrst_after%0d: %0d beats seen, need %h", k, rd_q.size(), exp_q[k]);
            end
        end
    endtask

    initial begin
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_write = 1'b0;
        bus.i_cmd_addr  = '0;
        bus.i_cmd_len   = '0;
        bus.i_wr_valid  = 1'b0;
        bus.i_wr_data   = '0;
        bus.i_rd_ready  = 1'b0;
        for (int k = 0; k < 64; k++) begin
            sram[k]    = rnd64();
            ref_mem[k] = sram[k];
        end
        clear_mon();
        test_reset();
        test_write_full();
        test_read_full();
        test_wrap();
        test_backpressure();
        test_gapped_writes();
        test_back_to_back();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_burst_ctrl.md
# sram_burst_ctrl

Burst request controller directly upstream of `sram_extension` (64 x 64-bit, four-bank SRAM). Accepts a single write or read burst command (start address, length) over a valid/ready handshake and streams write beats in or read beats out. Generates the SRAM's mutually exclusive `wen`/`oen` strobes, address and data, and buffers read returns in a 4-entry FIFO so the consumer can apply backpressure.

## Interface
- `DW`, 64, data width (matches SRAM word)
- `AW`, 6, address width (64 words)
- `FD`, 4, read-return FIFO depth (power of two, >= 3)
- `i_clk`  in  1  clock, rising edge
- `i_rst`  in  1  asynchronous, active-high reset
- `i_cmd_valid`  in  1  command valid
- `o_cmd_ready`  out  1  command accepted when valid & ready
- `i_cmd_write`  in  1  1 = write burst, 0 = read burst
- `i_cmd_addr`  in  AW  start word address
- `i_cmd_len`  in  AW  beats minus 1 (0 -> 1 beat, 63 -> 64 beats)
- `i_wr_valid` / `o_wr_ready`  in/out  1  write-beat handshake
- `i_wr_data`  in  DW  write beat
- `o_rd_valid` / `i_rd_ready`  out/in  1  read-beat handshake
- `o_rd_data`  out  DW  read beat (FIFO head)
- `o_done`  out  1  one-cycle pulse at burst completion
- `o_mem_data`  out  DW  to SRAM `i_data`
- `o_mem_addr`  out  AW  to SRAM `i_addr`
- `o_mem_wen`  out  1  to SRAM `i_wen`
- `o_mem_oen`  out  1  to SRAM `i_oen`
- `i_mem_data`  in  DW  from SRAM `o_data`

## Operation
- States: IDLE, WRITE, READ, DRAIN.
- IDLE: `o_cmd_ready`=1. On handshake, latch addr, remaining count = len+1; go WRITE if `i_cmd_write`, else READ.
- WRITE: `o_wr_ready`=1. Each `i_wr_valid` handshake registers `o_mem_wen`=1, `o_mem_addr`=current addr, `o_mem_data`=`i_wr_data` for the next cycle; addr increments. After last beat handshake -> IDLE; `o_done` pulses in the cycle `o_mem_wen` for the last beat is high.
- READ: issue one beat per cycle when `fifo_count + outstanding < FD` (registered values, no pop credit); issue registers `o_mem_oen`=1 with current addr for the next cycle. After last issue -> DRAIN.
- DRAIN: wait until outstanding = 0, FIFO empty; `o_done` pulses the cycle after last read-beat handshake; -> IDLE.
- Address increments modulo 64: 63 -> 0 wraps silently; len is never truncated.
- `o_mem_wen` and `o_mem_oen` are never both 1; both 0 whenever no beat is issued (SRAM STANDBY).
- FIFO: push `i_mem_data` at the end of the cycle after an `o_mem_oen` cycle; pop on `o_rd_valid & i_rd_ready`; simultaneous push/pop keeps count. Overflow is impossible by the issue rule.
- Commands are not accepted in WRITE/READ/DRAIN.

## Timing
- Reset (async assert, sync release): state IDLE, all outputs 0 including `o_cmd_ready`; `o_cmd_ready` goes 1 at first rising edge after release. FIFO, counters, outstanding cleared.
- Reset mid-burst: strobes drop immediately, burst abandoned, no `o_done`.
- Write latency: wr handshake at edge N -> `o_mem_wen` high cycle N..N+1 -> SRAM writes at edge N+1.
- Read latency: issue decision at edge N -> `o_mem_oen` high in cycle after N -> data pushed at edge N+2 -> `o_rd_valid` from edge N+2 (3 cycles command-to-data minimum when FIFO empty).
- Throughput: 1 beat/cycle both directions with `i_wr_valid`/`i_rd_ready` held high.
- Command accept to first memory strobe: 2 cycles (1 to enter state, 1 register).

## Test plan
- Write burst addr 0, len 63, data = addr, wr_valid held high -> 64 consecutive `o_mem_wen` cycles, addr 0..63, one `o_done`, `o_mem_oen` never 1.
- Read burst addr 0, len 63, rd_ready held high -> `o_rd_data` = 0..63 in order, 64 consecutive valid cycles after initial latency, `o_done` once.
- Wrap: write addr 62, len 3, data A0..A3 -> addresses 62,63,0,1; read addr 62 len 3 returns A0..A3.
- Backpressure: read 16 beats with `i_rd_ready` low 10 cycles -> at most 4 `o_mem_oen` cycles issued, no data loss, order preserved after release.
- Gapped writes: `i_wr_valid` toggling 1/0 -> `o_mem_wen` only on handshake cycles, all other cycles STANDBY.
- Reset asserted mid read burst (beat 5 of 10) -> strobes and `o_rd_valid` 0 immediately; after release `o_cmd_ready`=1, next command executes normally.
